// File: rtl/led_pkg.sv
// Shared types for the LED strip engine.
//   state_t : frame sequencer states
//   mode_t  : head-advance modes applied at every frame end
//   pixel_t : 24-bit GRB pixel, G in [23:16], R in [15:8], B in [7:0]
// Helper functions scale a pixel by the global brightness. They are only used when
// LED_BRIGHTNESS_EN is defined.
package led_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      LATCH = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_FWD    = 2'b01,
      MODE_BWD    = 2'b10,
      MODE_FREEZE = 2'b11
   } mode_t;

   typedef logic [23:0] pixel_t;

   localparam int unsigned BITS_PER_PIXEL = 24;
   // Wide enough for head + idx before the single wrap subtract
   localparam int unsigned ADDR_W = 9;

   // (c * (b + 1)) >> 8, so b = 255 leaves the channel unchanged
   function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
      logic [16:0] prod;
      prod = 17'(c) * (17'(b) + 17'd1);
      return 8'(prod >> 8);
   endfunction

   function automatic pixel_t scale_pixel(input pixel_t p, input logic [7:0] b);
      return {scale_channel(p[23:16], b), scale_channel(p[15:8], b), scale_channel(p[7:0], b)};
   endfunction

endpackage

// File: rtl/led_bit_encoder.sv
// Serialises one 24-bit pixel MSB first using single-wire LED timing.
// Each bit lasts BIT_CYC clocks. dout is high for the first T1H_CYC clocks of a 1 bit
// or the first T0H_CYC clocks of a 0 bit, and low for the rest of the period.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : accept 'pixel'. Valid when idle or in the cycle 'done' is high
//   pixel      : pixel to send
//   dout       : serial output, low while idle
//   done       : high in the final clock of the final bit of the current pixel
// Asserting load in the same cycle as done continues with no gap between pixels.
module led_bit_encoder
   import led_pkg::*;
#(
   parameter int unsigned T0H_CYC = 8,
   parameter int unsigned T1H_CYC = 16,
   parameter int unsigned BIT_CYC = 25
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  pixel_t pixel,
   output logic   dout,
   output logic   done
);

   localparam int unsigned CW = $clog2(BIT_CYC);
   localparam logic [CW-1:0] CycLast = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] Cyc0H   = CW'(T0H_CYC);
   localparam logic [CW-1:0] Cyc1H   = CW'(T1H_CYC);
   localparam logic [4:0]    BitLast = 5'(BITS_PER_PIXEL - 1);

   logic          active_q, active_d;
   pixel_t        shreg_q, shreg_d;
   logic [4:0]    bit_q, bit_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic          last_cyc, last_bit;

   assign last_cyc = (cyc_q == CycLast);
   assign last_bit = (bit_q == BitLast);
   assign done     = active_q && last_cyc && last_bit;
   assign dout     = active_q && (cyc_q < (shreg_q[23] ? Cyc1H : Cyc0H));

   always_comb begin
      active_d = active_q;
      shreg_d  = shreg_q;
      bit_d    = bit_q;
      cyc_d    = cyc_q;
      if (load) begin
         active_d = 1'b1;
         shreg_d  = pixel;
         bit_d    = 5'd0;
         cyc_d    = '0;
      end else if (active_q) begin
         if (!last_cyc) begin
            cyc_d = cyc_q + CW'(1);
         end else if (last_bit) begin
            active_d = 1'b0;
         end else begin
            shreg_d = {shreg_q[22:0], 1'b0};
            bit_d   = bit_q + 5'd1;
            cyc_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         shreg_q  <= '0;
         bit_q    <= 5'd0;
         cyc_q    <= '0;
      end else begin
         active_q <= active_d;
         shreg_q  <= shreg_d;
         bit_q    <= bit_d;
         cyc_q    <= cyc_d;
      end
   end

endmodule

// File: rtl/led_strip_engine.sv
// Double-buffered frame engine for a single-wire addressable LED strip.
// Pixels are written into the back buffer at any time. A swap request exchanges the
// front and back buffers. The swap happens at once when idle, and otherwise waits
// for the end of the current frame. Each frame sends NUM_PIXELS pixels starting at
// front[head], then holds the line low for RESET_CYC clocks. At frame end, 'mode'
// controls how head moves.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   enable             : run frames back to back while high
//   wr_en/addr/data    : back-buffer pixel write. Addresses >= NUM_PIXELS are dropped
//   swap_req           : single-cycle request to exchange the front and back buffers
//   mode               : 00 static, 01 rotate forward, 10 rotate backward, 11 freeze head
//   brightness         : global scale, used only with LED_BRIGHTNESS_EN
//   dout               : serial strip data
//   busy               : frame in progress
//   frame_done         : one-cycle pulse in the final latch clock
// Build option: define LED_BRIGHTNESS_EN to scale each channel by (brightness + 1) / 256
// when the pixel is loaded. Load timing does not change.
module led_strip_engine
   import led_pkg::*;
#(
   parameter int unsigned NUM_PIXELS = 144,
   parameter int unsigned T0H_CYC    = 8,
   parameter int unsigned T1H_CYC    = 16,
   parameter int unsigned BIT_CYC    = 25,
   parameter int unsigned RESET_CYC  = 1200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        wr_en,
   input  logic [7:0]  wr_addr,
   input  logic [23:0] wr_data,
   input  logic        swap_req,
   input  logic [1:0]  mode,
   input  logic [7:0]  brightness,
   output logic        dout,
   output logic        busy,
   output logic        frame_done
);

   localparam int unsigned MEM_DEPTH = 2 * NUM_PIXELS;
   localparam int unsigned MAW       = $clog2(MEM_DEPTH);
   localparam int unsigned LCW       = $clog2(RESET_CYC);

   localparam logic [7:0]        PixLast   = 8'(NUM_PIXELS - 1);
   localparam logic [ADDR_W-1:0] NumPix9   = ADDR_W'(NUM_PIXELS);
   localparam logic [LCW-1:0]    LatchLast = LCW'(RESET_CYC - 1);

   state_t         state_q, state_d;
   logic [7:0]     idx_q, idx_d;
   logic [7:0]     head_q, head_d;
   logic [LCW-1:0] latch_q, latch_d;
   logic           pend_q, pend_d;
   logic           front_q, front_d;

   logic           enc_load, enc_done;
   logic           last_pix, latch_last;
   mode_t          mode_sel;
   pixel_t         rd_pixel, load_pixel;

   // Bank 0 occupies [0, NUM_PIXELS) and bank 1 occupies [NUM_PIXELS, 2*NUM_PIXELS)
   pixel_t mem [MEM_DEPTH];

   assign last_pix   = (idx_q == PixLast);
   assign latch_last = (latch_q == LatchLast);
   assign mode_sel   = mode_t'(mode);

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable) state_d = LOAD;
         LOAD:    state_d = SHIFT;
         SHIFT:   if (enc_done && last_pix) state_d = LATCH;
         LATCH:   if (latch_last) state_d = enable ? LOAD : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      busy       = (state_q != IDLE);
      frame_done = (state_q == LATCH) && latch_last;
      // The first pixel loads in LOAD. Every later pixel loads in the last clock of
      // the previous pixel, so there is no gap between pixels.
      enc_load   = (state_q == LOAD) || ((state_q == SHIFT) && enc_done && !last_pix);
   end

   // ---------------------------------------------------------------- pixel buffers
   logic [7:0]        rd_idx;
   logic [ADDR_W-1:0] rd_sum, rd_pix;
   logic [MAW-1:0]    rd_mem_addr, wr_mem_addr;
   logic              wr_ok;

   always_comb begin
      rd_idx      = (state_q == LOAD) ? idx_q : idx_q + 8'd1;
      rd_sum      = {1'b0, head_q} + {1'b0, rd_idx};
      rd_pix      = (rd_sum >= NumPix9) ? rd_sum - NumPix9 : rd_sum;
      rd_mem_addr = MAW'(front_q ? rd_pix + NumPix9 : rd_pix);
      // The back bank is the one that is not front. It is selected before any swap
      // in this cycle takes effect.
      wr_ok       = wr_en && ({1'b0, wr_addr} < NumPix9);
      wr_mem_addr = MAW'(front_q ? {1'b0, wr_addr} : {1'b0, wr_addr} + NumPix9);
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_mem_addr] <= wr_data;
   end

   assign rd_pixel = mem[rd_mem_addr];

`ifdef LED_BRIGHTNESS_EN
   logic [7:0] bright_q;
   logic [7:0] bright_use;

   // Brightness is captured in LOAD and again at frame end. The LOAD pixel uses the
   // live port value so it matches what gets captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          bright_q <= 8'hFF;
      else if (state_q == LOAD || frame_done) bright_q <= brightness;
   end

   assign bright_use = (state_q == LOAD) ? brightness : bright_q;
   assign load_pixel = scale_pixel(rd_pixel, bright_use);
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;
   assign load_pixel        = rd_pixel;
`endif

   // ---------------------------------------------------------------- frame datapath
   always_comb begin
      idx_d   = idx_q;
      head_d  = head_q;
      latch_d = '0;
      pend_d  = pend_q;
      front_d = front_q;

      if ((state_q == SHIFT) && enc_done && !last_pix) idx_d = idx_q + 8'd1;
      if ((state_q == LATCH) && !latch_last) latch_d = latch_q + LCW'(1);

      if (frame_done) begin
         idx_d = 8'd0;
         unique case (mode_sel)
            MODE_STATIC: head_d = 8'd0;
            MODE_FWD:    head_d = (head_q == PixLast) ? 8'd0 : head_q + 8'd1;
            MODE_BWD:    head_d = (head_q == 8'd0) ? PixLast : head_q - 8'd1;
            MODE_FREEZE: head_d = head_q;
            default:     head_d = head_q;
         endcase
      end

      // A swap never happens mid-frame. It waits in pend_q until IDLE or frame end.
      if (((state_q == IDLE) || frame_done) && (pend_q || swap_req)) begin
         front_d = !front_q;
         pend_d  = 1'b0;
      end else if (swap_req) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= 8'd0;
         head_q  <= 8'd0;
         latch_q <= '0;
         pend_q  <= 1'b0;
         front_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         head_q  <= head_d;
         latch_q <= latch_d;
         pend_q  <= pend_d;
         front_q <= front_d;
      end
   end

   // ---------------------------------------------------------------- serialiser
   led_bit_encoder #(
      .T0H_CYC (T0H_CYC),
      .T1H_CYC (T1H_CYC),
      .BIT_CYC (BIT_CYC)
   ) u_encoder (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (enc_load),
      .pixel (load_pixel),
      .dout  (dout),
      .done  (enc_done)
   );

endmodule
